// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART receive byte assembler.
//   uart_rx_state_t         : FSM state encoding of the byte assembler
//   DEFAULT_SAMPLES_PER_BIT : default oversampling ratio
//   DEFAULT_DATA_BITS       : default data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        REARM  = 3'd5
    } uart_rx_state_t;

    localparam int unsigned DEFAULT_SAMPLES_PER_BIT = 8;
    localparam int unsigned DEFAULT_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_timer
// Counts sample_trigger strobes and flags the centre of each bit period.
// Ports:
//   clk               system clock
//   rst               asynchronous active-low reset
//   clear_i           holds the counter at zero (FSM not timing a bit)
//   sample_trigger_i  one-clk oversampling strobe
//   bit_centre_o      one-clk strobe, high on the SamplesPerBit-th trigger
// -----------------------------------------------------------------------------
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned SamplesPerBit = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic sample_trigger_i,
    output logic bit_centre_o
);

    localparam int unsigned    CntW    = $clog2(SamplesPerBit + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(SamplesPerBit - 1);

    logic [CntW-1:0] sample_cnt_q;
    logic [CntW-1:0] sample_cnt_d;
    logic            terminal;

    assign terminal = sample_trigger_i && (sample_cnt_q == LastCnt);

    always_comb begin
        // NOTE: default assignment first, so every path drives sample_cnt_d and no latch is inferred.
        sample_cnt_d = sample_cnt_q;
        if (clear_i || terminal) begin
            sample_cnt_d = '0;
        end else if (sample_trigger_i) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Combinational so the FSM samples raw_data in the same cycle as the trigger.
    assign bit_centre_o = terminal && !clear_i;

endmodule

// File: rtl/uart_rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// uart_rx_byte_assembler
// Samples the data and stop bits of a UART frame after start_bit_detector has
// found a start bit, emits the assembled word and flags framing errors, then
// re-arms the detector.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits (parameter ParityOdd, output parity_error).
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-low reset
//   sample_trigger      one-clk oversampling strobe
//   raw_data            synchronised RX line, idle high
//   start_bit_detected  level from start_bit_detector
//   detector_rst        one-clk synchronous reset to start_bit_detector
//   data                last correctly framed word
//   data_valid          one-clk pulse: data updated
//   framing_error       one-clk pulse: stop bit sampled low
//   busy                high in every state except IDLE
//   parity_error        (UART_RX_PARITY_EN only) one-clk pulse: parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_byte_assembler
    import uart_pkg::*;
#(
    parameter int unsigned SamplesPerBit = DEFAULT_SAMPLES_PER_BIT,
    parameter int unsigned DataBits      = DEFAULT_DATA_BITS
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          ParityOdd     = 1'b0
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_trigger,
    input  logic                raw_data,
    input  logic                start_bit_detected,
    output logic                detector_rst,
    output logic [DataBits-1:0] data,
    output logic                data_valid,
    output logic                framing_error,
    output logic                busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                parity_error
`endif
);

    localparam int unsigned     IdxW    = $clog2(DataBits + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DataBits - 1);

    uart_rx_state_t      state_q;
    logic [IdxW-1:0]     bit_idx_q;
    logic [DataBits-1:0] shift_q;
    logic [DataBits-1:0] data_q;
    logic                detector_rst_q;
    logic                data_valid_q;
    logic                framing_error_q;
    logic                busy_q;
    logic                timer_clear;
    logic                bit_centre;
`ifdef UART_RX_PARITY_EN
    logic                parity_bad_q;
    logic                parity_error_q;
`endif

    // The timer only runs while a bit is being timed; IDLE holds it at zero so
    // the first data bit is measured from the detection point.
    assign timer_clear = state_q inside {IDLE, BREAK, REARM};

    uart_rx_bit_timer #(
        .SamplesPerBit(SamplesPerBit)
    ) u_bit_timer (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (timer_clear),
        .sample_trigger_i(sample_trigger),
        .bit_centre_o    (bit_centre)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= REARM;
            detector_rst_q  <= 1'b1;
            busy_q          <= 1'b1;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= 1'b0;
`endif
            unique case (state_q)
                REARM: begin
                    state_q        <= IDLE;
                    detector_rst_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
                IDLE: begin
                    if (start_bit_detected) begin
                        state_q   <= DATA;
                        busy_q    <= 1'b1;
                        bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_bad_q <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (bit_centre) begin
                        // LSB arrives first, so shifting right leaves it at bit 0.
                        shift_q <= {raw_data, shift_q[DataBits-1:1]};
                        if (bit_idx_q == LastIdx) begin
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_centre) begin
                        parity_bad_q <= (raw_data != ((^shift_q) ^ ParityOdd));
                        state_q      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_centre) begin
                        if (raw_data) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_error_q <= 1'b1;
                            end else begin
                                data_q       <= shift_q;
                                data_valid_q <= 1'b1;
                            end
`else
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
`endif
                            state_q        <= REARM;
                            detector_rst_q <= 1'b1;
                        end else begin
                            // Detector is left latched so a held-low line cannot re-trigger it.
                            framing_error_q <= 1'b1;
                            state_q         <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (sample_trigger && raw_data) begin
                        state_q        <= REARM;
                        detector_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= REARM;
                    detector_rst_q <= 1'b1;
                    busy_q         <= 1'b1;
                end
            endcase
        end
    end

    assign detector_rst  = detector_rst_q;
    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte_assembler
// Bench for uart_rx_byte_assembler with a behavioural start-bit detector and a
// sample_trigger generator (one strobe every 10 clk, 8 strobes per bit).
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_byte_assembler;

    localparam int SPB         = 8;
    localparam int DB          = 8;
    localparam int TRIG_PERIOD = 10;
    localparam int CLK_PER_BIT = SPB * TRIG_PERIOD;
    localparam bit PARITY_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TRIGS = 80;  // 8 data + parity + stop, 8 triggers each
`else
    localparam int FRAME_TRIGS = 72;  // 8 data + stop, 8 triggers each
`endif

    typedef enum int { EV_DATA = 1, EV_FRAME = 2, EV_PARITY = 3 } ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [DB-1:0] byte_v;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_trigger = 1'b0;
    logic          raw_data = 1'b1;
    logic          start_bit_detected = 1'b0;
    logic          detector_rst;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          framing_error;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_error;
`endif

    int  vectors    = 0;
    int  miscompares = 0;
    int  dv_cnt = 0;
    int  fe_cnt = 0;
    int  pe_cnt = 0;
    ev_t expq[$];

    always #5 clk = ~clk;

    uart_rx_byte_assembler #(
        .SamplesPerBit(SPB),
        .DataBits     (DB)
`ifdef UART_RX_PARITY_EN
        ,
        .ParityOdd    (PARITY_ODD)
`endif
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .sample_trigger    (sample_trigger),
        .raw_data          (raw_data),
        .start_bit_detected(start_bit_detected),
        .detector_rst      (detector_rst),
        .data              (data),
        .data_valid        (data_valid),
        .framing_error     (framing_error),
        .busy              (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error      (parity_error)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- sample_trigger generator: one strobe every 10 clk ----
    initial begin
        forever begin
            repeat (TRIG_PERIOD - 1) @(posedge clk);
            #1 sample_trigger = 1'b1;
            @(posedge clk);
            #1 sample_trigger = 1'b0;
        end
    end

    // ---------------- start-bit detector: 4 low triggers -> latched level --
    initial begin : start_detector
        int low_cnt;
        int nlow;
        bit nxt;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            nxt  = start_bit_detected;
            nlow = low_cnt;
            if (!rst || detector_rst) begin
                nxt  = 1'b0;
                nlow = 0;
            end else if (sample_trigger && !start_bit_detected) begin
                if (!raw_data) begin
                    nlow = low_cnt + 1;
                    if (nlow == SPB / 2) nxt = 1'b1;
                end else begin
                    nlow = 0;
                end
            end
            @(posedge clk);
            #1;
            start_bit_detected = nxt;
            low_cnt            = nlow;
        end
    end

    // ---------------- frame-level model ------------------------------------
    function automatic logic good_parity(input logic [DB-1:0] b);
        return (($countones(b) % 2) == 1) ^ PARITY_ODD;
    endfunction

    function automatic void model_frame(input logic [DB-1:0] b, input logic stop_v, input logic par_v);
        ev_t e;
        e.byte_v = b;
        e.kind   = EV_DATA;
        if (!stop_v) begin
            e.kind = EV_FRAME;
        end
`ifdef UART_RX_PARITY_EN
        else if (par_v != good_parity(b)) begin
            e.kind = EV_PARITY;
        end
`endif
        if (par_v === 1'bx) e.kind = EV_FRAME;  // never taken: par_v is always driven 0/1
        expq.push_back(e);
    endfunction

    // ---------------- compare process (every cycle, negedge) ---------------
    initial begin : compare
        logic [DB-1:0] model_data;
        int            trig_since;
        bit            sbd_prev;
        bit            rearm_pending;
        bit            pe;
        int            dut_kind;
        ev_t           e;
        model_data    = '0;
        trig_since    = 0;
        sbd_prev      = 1'b0;
        rearm_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_data    = '0;
                trig_since    = 0;
                sbd_prev      = 1'b0;
                rearm_pending = 1'b0;
                continue;
            end
`ifdef UART_RX_PARITY_EN
            pe = parity_error;
`else
            pe = 1'b0;
`endif
            if (rearm_pending) begin
                check("rearm_within_2clk", 32'(detector_rst), 32'd1);
                rearm_pending = 1'b0;
            end
            check("dv_fe_exclusive", 32'(data_valid & framing_error), 32'd0);
            if (data_valid || framing_error || pe) begin
                dut_kind = data_valid ? 1 : (framing_error ? 2 : 3);
                if (data_valid) dv_cnt++;
                if (framing_error) fe_cnt++;
                if (pe) pe_cnt++;
                if (expq.size() == 0) begin
                    check("unexpected_pulse", 32'(dut_kind), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("pulse_kind", 32'(dut_kind), 32'(int'(e.kind)));
                    check("pulse_latency_trigs", 32'(trig_since), 32'(FRAME_TRIGS));
                    if (e.kind == EV_DATA) model_data = e.byte_v;
                    if (framing_error) check("fe_keeps_detector", 32'(detector_rst), 32'd0);
                    else if (!detector_rst) rearm_pending = 1'b1;
                end
            end
            check("data", 32'(data), 32'(model_data));
            if (start_bit_detected && !sbd_prev) trig_since = 0;
            if (sample_trigger) trig_since++;
            sbd_prev = start_bit_detected;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic hold(input logic b, input int nbits);
        raw_data = b;
        repeat (nbits * CLK_PER_BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input logic par_v);
        model_frame(b, stop_v, par_v);
        hold(1'b0, 1);
        for (int i = 0; i < DB; i++) hold(b[i], 1);
`ifdef UART_RX_PARITY_EN
        hold(par_v, 1);
`endif
        hold(stop_v, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_detector_rst"}, 32'(detector_rst), 32'd1);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_framing_error"}, 32'(framing_error), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic send_aborted(input logic [DB-1:0] b, input int abort_bit);
        hold(1'b0, 1);
        for (int i = 0; i < abort_bit; i++) hold(b[i], 1);
        raw_data = b[abort_bit];
        repeat (CLK_PER_BIT / 2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_values("abort_rst");
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        raw_data = 1'b1;
    endtask

    // ---------------- watchdog ----------------------------------------------
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 clk budget");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        int dv0;
        int fe0;
        int pe0;
        rst      = 1'b0;
        raw_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 2);

        // 1: single frame 0xA5
        dv0 = dv_cnt;
        send_frame(8'hA5, 1'b1, good_parity(8'hA5));
        hold(1'b1, 1);
        check("t1_data", 32'(data), 32'h0000_00A5);
        check("t1_valid_count", 32'(dv_cnt - dv0), 32'd1);

        // 2: back-to-back 0x00, 0xFF
        dv0 = dv_cnt;
        send_frame(8'h00, 1'b1, good_parity(8'h00));
        send_frame(8'hFF, 1'b1, good_parity(8'hFF));
        hold(1'b1, 1);
        check("t2_data", 32'(data), 32'h0000_00FF);
        check("t2_valid_count", 32'(dv_cnt - dv0), 32'd2);

        // 3: framing error with line held low for 20 bits, then recovery
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, good_parity(8'h3C));
        hold(1'b0, 19);
        check("t3_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("t3_valid_count", 32'(dv_cnt - dv0), 32'd0);
        check("t3_busy_in_break", 32'(busy), 32'd1);
        check("t3_data_kept", 32'(data), 32'h0000_00FF);
        hold(1'b1, 2);
        send_frame(8'h5A, 1'b1, good_parity(8'h5A));
        hold(1'b1, 1);
        check("t3_next_data", 32'(data), 32'h0000_005A);

        // 4: reset at data bit 4 of 0x81, then 0x42
        dv0 = dv_cnt;
        send_aborted(8'h81, 4);
        hold(1'b1, 2);
        check("t4_no_pulse", 32'(dv_cnt - dv0), 32'd0);
        check("t4_data_cleared", 32'(data), 32'd0);
        send_frame(8'h42, 1'b1, good_parity(8'h42));
        hold(1'b1, 1);
        check("t4_next_data", 32'(data), 32'h0000_0042);

        // 5: 500 clk of idle line with triggers running
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (i % 50 == 0) check("t5_busy_idle", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        check("t5_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, 0x07 has three ones -> parity bit must be 1
        dv0 = dv_cnt;
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 1);
        check("t6_good_parity_data", 32'(data), 32'h0000_0007);
        check("t6_good_parity_valid", 32'(dv_cnt - dv0), 32'd1);
        dv0 = dv_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 1);
        check("t6_bad_parity_pulse", 32'(pe_cnt - pe0), 32'd1);
        check("t6_bad_parity_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("t6_bad_parity_data_kept", 32'(data), 32'h0000_0007);
`else
        pe0 = pe_cnt;
        check("no_parity_pulses", 32'(pe_cnt - pe0), 32'd0);
`endif

        check("expected_queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
